// File: rtl/vga_sprite_compositor_if.sv
// Object attribute write bus for vga_sprite_compositor.
// The game logic (master) drives one object's full attribute set per write.
// Ports / signals:
//   obj_we     write strobe, sampled on every clk (independent of pix_en)
//   obj_sel    index of the object being written; indices >= NUM_OBJ are ignored
//   obj_x/y    top-left corner of the rectangle
//   obj_w/h    rectangle size; zero in either dimension hides the object
//   obj_color  {R,G,B} 4 bits each
//   obj_en     object visible
interface vga_sprite_compositor_if #(
  parameter int NUM_OBJ = 4,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  localparam int SEL_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  logic             obj_we;
  logic [SEL_W-1:0] obj_sel;
  logic [X_W-1:0]   obj_x;
  logic [Y_W-1:0]   obj_y;
  logic [X_W-1:0]   obj_w;
  logic [Y_W-1:0]   obj_h;
  logic [11:0]      obj_color;
  logic             obj_en;

  modport master (
    output obj_we, obj_sel, obj_x, obj_y, obj_w, obj_h, obj_color, obj_en
  );

  modport slave (
    input obj_we, obj_sel, obj_x, obj_y, obj_w, obj_h, obj_color, obj_en
  );
endinterface

// File: rtl/vga_sprite_compositor.sv
// VGA timing generator and rectangle sprite compositor.
// Generates the raster counters and sync pulses, composites NUM_OBJ solid
// rectangles (index 0 on top) over a caller-supplied background colour and
// accumulates per-object overlap flags. Object attributes are written into a
// shadow bank at any time and copied to the live bank only at the start of
// vertical blank, so a frame is always drawn from one consistent set.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   pix_en       pixel strobe; raster, pipeline and collision state advance only on it
//   obj_bus      shadow attribute write bus (slave side)
//   bg_color     background colour for the current stage-0 (x,y)
//   x, y, active stage-0 raster position and visible-area flag
//   screenEnd    single-cycle strobe on the pixel where the live bank is committed
//   hSync,vSync  active-low sync, aligned with VGA_*
//   VGA_R/G/B    composited colour, one pixel behind x/y
//   coll_flags   objects that overlapped another object during the previous frame
module vga_sprite_compositor #(
  parameter int NUM_OBJ  = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_en,
  vga_sprite_compositor_if.slave   obj_bus,
  input  logic [11:0]              bg_color,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic                     active,
  output logic                     screenEnd,
  output logic                     hSync,
  output logic                     vSync,
  output logic [3:0]               VGA_R,
  output logic [3:0]               VGA_G,
  output logic [3:0]               VGA_B,
  output logic [NUM_OBJ-1:0]       coll_flags
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least as wide as the coordinate outputs; the vertical
  // counter may be wider than Y_W (525 lines needs 10 bits), y is truncated.
  localparam int HC_W  = ($clog2(H_TOTAL) > X_W) ? $clog2(H_TOTAL) : X_W;
  localparam int VC_W  = ($clog2(V_TOTAL) > Y_W) ? $clog2(V_TOTAL) : Y_W;
  localparam int SEL_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]  HS_START   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  HS_END     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_ACT_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  VS_START   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  VS_END     = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0]  V_LAST_ACT = VC_W'(V_ACTIVE - 1);
  localparam logic [SEL_W:0]   NUM_OBJ_L  = (SEL_W + 1)'(NUM_OBJ);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic [11:0]    color;
    logic           en;
  } obj_t;

  logic [HC_W-1:0]    hcnt_r;
  logic [VC_W-1:0]    vcnt_r;
  obj_t               shadow_r [NUM_OBJ];
  obj_t               live_r   [NUM_OBJ];
  logic [NUM_OBJ-1:0] coll_acc_r;
  logic [NUM_OBJ-1:0] coll_flags_r;
  logic [11:0]        rgb_r;
  logic               hsync_r;
  logic               vsync_r;

  logic               h_wrap_s;
  logic               commit_s;
  logic               active_s;
  logic [NUM_OBJ-1:0] hit_s;
  logic               multi_hit_s;
  logic [11:0]        sel_color_s;
  logic [11:0]        rgb_next_s;
  logic               hsync_next_s;
  logic               vsync_next_s;
  logic               wr_valid_s;
  obj_t               wr_obj_s;

  assign x        = hcnt_r[X_W-1:0];
  assign y        = vcnt_r[Y_W-1:0];
  assign h_wrap_s = (hcnt_r == H_LAST);
  assign active_s = (hcnt_r < H_ACT_END) && (vcnt_r < V_ACT_END);
  assign active   = active_s;

  // The commit pixel is the last pixel of the last visible line: its pix_en
  // edge moves the raster into the first blanking line.
  assign commit_s  = pix_en && h_wrap_s && (vcnt_r == V_LAST_ACT);
  assign screenEnd = commit_s;

  // Stage-0 hit test. The right/bottom edges are formed one bit wider than
  // the coordinates so an object hanging off the far edge cannot wrap round.
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
    logic [X_W:0] x_end_s;
    logic [Y_W:0] y_end_s;
    assign x_end_s   = {1'b0, live_r[gi].x} + {1'b0, live_r[gi].w};
    assign y_end_s   = {1'b0, live_r[gi].y} + {1'b0, live_r[gi].h};
    assign hit_s[gi] = live_r[gi].en
                    && (x >= live_r[gi].x) && ({1'b0, x} < x_end_s)
                    && (y >= live_r[gi].y) && ({1'b0, y} < y_end_s);
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit_s = ((hit_s & (hit_s - NUM_OBJ'(1))) != '0);

  // Priority select: walk from the lowest-priority object down so index 0 wins.
  always_comb begin
    sel_color_s = bg_color;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      sel_color_s = hit_s[i] ? live_r[i].color : sel_color_s;
    end
  end

  // Blank the colour outside the visible area and decode the sync windows.
  always_comb begin
    rgb_next_s   = active_s ? sel_color_s : 12'h000;
    hsync_next_s = !((hcnt_r >= HS_START) && (hcnt_r < HS_END));
    vsync_next_s = !((vcnt_r >= VS_START) && (vcnt_r < VS_END));
  end

  // Decode a shadow write; out-of-range indices are dropped.
  always_comb begin
    wr_valid_s     = obj_bus.obj_we && ({1'b0, obj_bus.obj_sel} < NUM_OBJ_L);
    wr_obj_s.x     = obj_bus.obj_x;
    wr_obj_s.y     = obj_bus.obj_y;
    wr_obj_s.w     = obj_bus.obj_w;
    wr_obj_s.h     = obj_bus.obj_h;
    wr_obj_s.color = obj_bus.obj_color;
    wr_obj_s.en    = obj_bus.obj_en;
  end

  // Raster counters: hcnt per pixel, vcnt per line, both wrapping to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_r <= '0;
      vcnt_r <= '0;
    end else if (pix_en) begin
      if (h_wrap_s) begin
        hcnt_r <= '0;
        vcnt_r <= (vcnt_r == V_LAST) ? '0 : vcnt_r + VC_W'(1);
      end else begin
        hcnt_r <= hcnt_r + HC_W'(1);
      end
    end
  end

  // Output stage: colour and both syncs register together so they stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_r   <= 12'h000;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_en) begin
      rgb_r   <= rgb_next_s;
      hsync_r <= hsync_next_s;
      vsync_r <= vsync_next_s;
    end
  end

  // Shadow bank: written on any clk, pix_en does not gate it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_r[i] <= '0;
      end
    end else if (wr_valid_s) begin
      shadow_r[obj_bus.obj_sel] <= wr_obj_s;
    end
  end

  // Live bank: copied from shadow at commit. A write on the same edge is not
  // seen here because shadow_r still holds its pre-write value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        live_r[i] <= '0;
      end
    end else if (commit_s) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        live_r[i] <= shadow_r[i];
      end
    end
  end

  // Overlap accumulation over the visible area, published once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_acc_r   <= '0;
      coll_flags_r <= '0;
    end else if (pix_en) begin
      if (commit_s) begin
        coll_flags_r <= coll_acc_r;
        coll_acc_r   <= '0;
      end else if (active_s && multi_hit_s) begin
        coll_acc_r <= coll_acc_r | hit_s;
      end
    end
  end

  assign VGA_R      = rgb_r[11:8];
  assign VGA_G      = rgb_r[7:4];
  assign VGA_B      = rgb_r[3:0];
  assign hSync      = hsync_r;
  assign vSync      = vsync_r;
  assign coll_flags = coll_flags_r;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor on a shrunken raster
// (16x12 visible, 24x17 total) so whole frames fit in a short run.
module tb_vga_sprite_compositor;
  localparam int NUM_OBJ = 5;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic               clk = 1'b0;
  logic               reset;
  logic               pix_en;
  logic [11:0]        bg_color;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               active;
  logic               screenEnd;
  logic               hSync;
  logic               vSync;
  logic [3:0]         VGA_R, VGA_G, VGA_B;
  logic [NUM_OBJ-1:0] coll_flags;
  logic [11:0]        rgb;
  logic               pa;

  int checks = 0;
  int errors = 0;
  int th = 0, tv = 0, ph = 0, pv = 0;

  vga_sprite_compositor_if #(.NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W)) obj_bus ();

  vga_sprite_compositor #(
    .NUM_OBJ(NUM_OBJ), .X_W(X_W), .Y_W(Y_W),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .obj_bus(obj_bus),
    .bg_color(bg_color), .x(x), .y(y), .active(active), .screenEnd(screenEnd),
    .hSync(hSync), .vSync(vSync), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .coll_flags(coll_flags)
  );

  assign rgb = {VGA_R, VGA_G, VGA_B};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at model (%0d,%0d)", tag, obs, exp, th, tv);
    end
  endtask

  // One pixel: th/tv track the stage-0 position, ph/pv the pixel now on VGA_*.
  task automatic step();
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    ph = th;
    pv = tv;
    if (th == HT - 1) begin
      th = 0;
      tv = (tv == VT - 1) ? 0 : tv + 1;
    end else begin
      th = th + 1;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(th == h && tv == v) && n < HT * VT) begin
      step();
      n++;
    end
    chk("pos_x", x, h);
    chk("pos_y", y, v);
  endtask

  task automatic pixel_chk(input int h, input int v, input logic [11:0] exp, input string tag);
    run_to(h, v);
    step();
    chk(tag, rgb, exp);
  endtask

  task automatic obj_write(input int sel, input int ox, input int oy, input int ow,
                           input int oh, input logic [11:0] col, input logic en);
    pix_en            = 1'b0;
    obj_bus.obj_sel   = 3'(sel);
    obj_bus.obj_x     = 10'(ox);
    obj_bus.obj_y     = 9'(oy);
    obj_bus.obj_w     = 10'(ow);
    obj_bus.obj_h     = 9'(oh);
    obj_bus.obj_color = col;
    obj_bus.obj_en    = en;
    obj_bus.obj_we    = 1'b1;
    @(posedge clk);
    #1;
    obj_bus.obj_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    pix_en = 1'b0;
    bg_color = 12'h00F;
    obj_bus.obj_we = 1'b0;
    obj_bus.obj_sel = 3'd0;
    obj_bus.obj_x = 10'd0;
    obj_bus.obj_y = 9'd0;
    obj_bus.obj_w = 10'd0;
    obj_bus.obj_h = 9'd0;
    obj_bus.obj_color = 12'h000;
    obj_bus.obj_en = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", hSync, 1);
    chk("rst_vsync", vSync, 1);
    chk("rst_screen_end", screenEnd, 0);
    chk("rst_coll", coll_flags, 0);
    reset = 1'b1;
    th = 0;
    tv = 0;

    // Frame 0: background only, full timing check on every pixel
    for (int i = 0; i < HT * VT; i++) begin
      step();
      pa = (ph < HA) && (pv < VA);
      chk("f0_rgb", rgb, pa ? 12'h00F : 12'h000);
      chk("f0_hsync", hSync, !((ph >= HA + HF) && (ph < HA + HF + HS)));
      chk("f0_vsync", vSync, !((pv >= VA + VF) && (pv < VA + VF + VS)));
      chk("f0_screen_end", screenEnd, (th == HT - 1) && (tv == VA - 1));
      chk("f0_active", active, (th < HA) && (tv < VA));
      chk("f0_x", x, th);
      chk("f0_y", y, tv);
    end

    // Frame 1: mid-frame write must not appear yet; pix_en=0 holds everything
    run_to(0, 2);
    obj_write(0, 5, 3, 4, 3, 12'hFFF, 1'b1);
    pixel_chk(5, 3, 12'h00F, "pending_not_drawn");
    run_to(2, 4);
    pix_en = 1'b0;
    bg_color = 12'hABC;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_x", x, 2);
    chk("hold_y", y, 4);
    chk("hold_rgb", rgb, 12'h00F);
    bg_color = 12'h00F;

    // Frame 2: white 4x3 box at (5,3)
    run_to(0, 0);
    chk("f2_coll", coll_flags, 5'b00000);
    pixel_chk(4, 3, 12'h00F, "box_left_out");
    pixel_chk(5, 3, 12'hFFF, "box_top_left");
    pixel_chk(9, 3, 12'h00F, "box_right_out");
    pixel_chk(8, 5, 12'hFFF, "box_bot_right");
    pixel_chk(5, 6, 12'h00F, "box_below_out");
    run_to(0, 7);
    obj_write(0, 2, 2, 4, 4, 12'hF00, 1'b1);
    obj_write(1, 4, 4, 4, 4, 12'h0F0, 1'b1);

    // Frame 3: overlapping red (obj0) and green (obj1)
    run_to(0, 0);
    chk("f3_coll", coll_flags, 5'b00000);
    pixel_chk(3, 3, 12'hF00, "red_only");
    pixel_chk(5, 5, 12'hF00, "overlap_prio0");
    pixel_chk(7, 7, 12'h0F0, "green_only");
    pixel_chk(8, 8, 12'h00F, "green_right_out");
    run_to(0, 9);
    obj_write(0, 2, 2, 4, 4, 12'hF00, 1'b0);
    obj_write(1, 4, 4, 4, 4, 12'h0F0, 1'b0);
    obj_write(2, 14, 0, 1020, 12, 12'h8A5, 1'b1);
    obj_write(3, 3, 9, 0, 3, 12'hFFF, 1'b1);
    obj_write(4, 15, 0, 1, 1, 12'h123, 1'b1);

    // Frame 4: right-edge object, zero-width object
    run_to(0, 0);
    chk("f4_coll", coll_flags, 5'b00011);
    pixel_chk(13, 0, 12'h00F, "edge_left_out");
    pixel_chk(14, 0, 12'h8A5, "edge_first");
    pixel_chk(15, 0, 12'h8A5, "edge_last_prio");
    pixel_chk(16, 0, 12'h000, "edge_blank");
    pixel_chk(0, 1, 12'h00F, "edge_no_wrap");
    pixel_chk(15, 1, 12'h8A5, "edge_row1");
    pixel_chk(3, 9, 12'h00F, "zero_w_hidden");
    run_to(HT - 1, VA - 1);
    chk("commit_screen_end", screenEnd, 1);
    obj_bus.obj_sel = 3'd2;
    obj_bus.obj_x = 10'd10;
    obj_bus.obj_y = 9'd0;
    obj_bus.obj_w = 10'd1020;
    obj_bus.obj_h = 9'd12;
    obj_bus.obj_color = 12'h8A5;
    obj_bus.obj_en = 1'b1;
    obj_bus.obj_we = 1'b1;
    step();
    obj_bus.obj_we = 1'b0;
    chk("commit_coll", coll_flags, 5'b10100);
    chk("post_commit_screen_end", screenEnd, 0);

    // Frame 5: commit-cycle write not yet live; out-of-range index write
    run_to(0, 0);
    pixel_chk(10, 0, 12'h00F, "commit_wr_old");
    pixel_chk(14, 0, 12'h8A5, "commit_wr_old_obj");
    run_to(0, 2);
    obj_write(5, 0, 0, 16, 12, 12'hFFF, 1'b1);

    // Frame 6: commit-cycle write now live; bad index had no effect
    run_to(0, 0);
    chk("f6_coll", coll_flags, 5'b10100);
    pixel_chk(9, 0, 12'h00F, "new_x_left_out");
    pixel_chk(10, 0, 12'h8A5, "new_x_drawn");
    pixel_chk(1, 1, 12'h00F, "bad_sel_ignored");

    // Mid-frame reset while objects are shown
    run_to(1, 8);
    chk("pre_rst_rgb", rgb, 12'h00F);
    chk("pre_rst_coll", coll_flags, 5'b10100);
    reset = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 12'h000);
    chk("mid_rst_hsync", hSync, 1);
    chk("mid_rst_vsync", vSync, 1);
    chk("mid_rst_coll", coll_flags, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_y", y, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    th = 0;
    tv = 0;
    chk("rel_x", x, 0);
    chk("rel_y", y, 0);
    pixel_chk(14, 0, 12'h00F, "rst_live_clear");
    run_to(0, 0);
    chk("rst_coll_next", coll_flags, 0);
    pixel_chk(14, 0, 12'h00F, "rst_shadow_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
